// File: rtl/rc4_pkg.sv
// Shared constants, FSM state encoding and helpers for the RC4 decryption stage.
package rc4_pkg;

    localparam int S_SIZE    = 256;
    localparam int KEY_BYTES = 3;

    localparam logic [7:0] CHAR_LO    = 8'd97;
    localparam logic [7:0] CHAR_HI    = 8'd122;
    localparam logic [7:0] CHAR_SPACE = 8'd32;

    typedef enum logic [3:0] {
        FILL   = 4'd0,
        KSA_RI = 4'd1,
        KSA_RJ = 4'd2,
        KSA_CJ = 4'd3,
        KSA_WI = 4'd4,
        KSA_WJ = 4'd5,
        PR_RI  = 4'd6,
        PR_RJ  = 4'd7,
        PR_CJ  = 4'd8,
        PR_WI  = 4'd9,
        PR_WJ  = 4'd10,
        PR_RF  = 4'd11,
        PR_CF  = 4'd12,
        PR_WD  = 4'd13,
        DONE   = 4'd14
    } rc4_state_e;

    // A message of one byte still needs a one-bit address bus.
    function automatic int addr_width(input int len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

    function automatic logic is_text(input logic [7:0] b);
        return ((b >= CHAR_LO) && (b <= CHAR_HI)) || (b == CHAR_SPACE);
    endfunction

endpackage

// File: rtl/rc4_decrypt_if.sv
// Memory-side bus of the RC4 decryption stage: S RAM, encrypted ROM and decrypted RAM.
interface rc4_decrypt_if #(parameter int MSG_LEN = 32);

    localparam int AW = rc4_pkg::addr_width(MSG_LEN);

    logic [7:0]    s_addr;
    logic [7:0]    s_wdata;
    logic          s_wren;
    logic [7:0]    s_rdata;
    logic [AW-1:0] enc_addr;
    logic [7:0]    enc_rdata;
    logic [AW-1:0] dec_addr;
    logic [7:0]    dec_wdata;
    logic          dec_wren;

    modport master (
        output s_addr, s_wdata, s_wren,
        input  s_rdata,
        output enc_addr,
        input  enc_rdata,
        output dec_addr, dec_wdata, dec_wren
    );

    modport slave (
        input  s_addr, s_wdata, s_wren,
        output s_rdata,
        input  enc_addr,
        output enc_rdata,
        input  dec_addr, dec_wdata, dec_wren
    );

endinterface

// File: rtl/rc4_keybyte_sel.sv
// Selects key byte (i mod 3) for the key schedule using a wrapping counter instead of a divider.
module rc4_keybyte_sel
    import rc4_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        advance,
    input  logic [23:0] key_q,
    output logic [7:0]  key_byte
);

    logic [1:0] sel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel <= 2'd0;
        end else if (clear) begin
            sel <= 2'd0;
        end else if (advance) begin
            sel <= (sel == 2'(KEY_BYTES - 1)) ? 2'd0 : sel + 2'd1;
        end
    end

    always_comb begin
        case (sel)
            2'd0:    key_byte = key_q[23:16];
            2'd1:    key_byte = key_q[15:8];
            default: key_byte = key_q[7:0];
        endcase
    end

endmodule

// File: rtl/rc4_decrypt.sv
// RC4 decryption stage: key schedule then keystream XOR into the decrypted RAM for each candidate key.
// Optional early abort on non-text output is enabled by defining RC4_EARLY_ABORT_EN.
module rc4_decrypt
    import rc4_pkg::*;
#(
    parameter int MSG_LEN = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [23:0]   key,
    input  logic          initialize,
    output logic          done,
    output logic          invalid,
    rc4_decrypt_if.master mem
);

    localparam int            AW     = addr_width(MSG_LEN);
    localparam logic [AW-1:0] LAST_K = AW'(MSG_LEN - 1);

    rc4_state_e    state;
    logic          active;
    logic [7:0]    i, j, si, sj, f_q, e_q;
    logic [AW-1:0] k;
    logic [23:0]   key_q;
    logic [7:0]    key_byte;
    logic          abort;

    rc4_keybyte_sel u_keysel (
        .clk      (clk),
        .reset    (reset),
        .clear    (state == FILL),
        .advance  (state == KSA_WJ),
        .key_q    (key_q),
        .key_byte (key_byte)
    );

`ifdef RC4_EARLY_ABORT_EN
    logic invalid_q;

    assign abort   = !is_text(f_q ^ e_q);
    assign invalid = invalid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            invalid_q <= 1'b0;
        end else if (active) begin
            if (initialize) begin
                invalid_q <= 1'b0;
            end else if (state == PR_WD && abort) begin
                invalid_q <= 1'b1;
            end
        end
    end
`else
    assign abort   = 1'b0;
    assign invalid = 1'b0;
`endif

    // The first cycle after reset only arms the block, so reset leaves every write strobe low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= FILL;
            active <= 1'b0;
            i      <= 8'd0;
            j      <= 8'd0;
            k      <= '0;
            si     <= 8'd0;
            sj     <= 8'd0;
            f_q    <= 8'd0;
            e_q    <= 8'd0;
            key_q  <= 24'd0;
        end else if (!active) begin
            active <= 1'b1;
        end else if (initialize) begin
            state <= FILL;
            i     <= 8'd0;
            j     <= 8'd0;
            k     <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (i == 8'd0) key_q <= key;
                    i <= i + 8'd1;
                    if (i == 8'(S_SIZE - 1)) state <= KSA_RI;
                end
                KSA_RI: state <= KSA_RJ;
                KSA_RJ: begin
                    si    <= mem.s_rdata;
                    j     <= j + mem.s_rdata + key_byte;
                    state <= KSA_CJ;
                end
                KSA_CJ: begin
                    sj    <= mem.s_rdata;
                    state <= KSA_WI;
                end
                KSA_WI: state <= KSA_WJ;
                KSA_WJ: begin
                    i <= i + 8'd1;
                    if (i == 8'(S_SIZE - 1)) begin
                        j     <= 8'd0;
                        state <= PR_RI;
                    end else begin
                        state <= KSA_RI;
                    end
                end
                PR_RI: begin
                    i     <= i + 8'd1;
                    state <= PR_RJ;
                end
                PR_RJ: begin
                    si    <= mem.s_rdata;
                    j     <= j + mem.s_rdata;
                    state <= PR_CJ;
                end
                PR_CJ: begin
                    sj    <= mem.s_rdata;
                    state <= PR_WI;
                end
                PR_WI: state <= PR_WJ;
                PR_WJ: state <= PR_RF;
                PR_RF: state <= PR_CF;
                PR_CF: begin
                    f_q   <= mem.s_rdata;
                    e_q   <= mem.enc_rdata;
                    state <= PR_WD;
                end
                PR_WD: begin
                    k     <= k + AW'(1);
                    state <= (k == LAST_K || abort) ? DONE : PR_RI;
                end
                DONE:    state <= DONE;
                default: state <= FILL;
            endcase
        end
    end

    // Read addresses that depend on freshly returned data are formed combinationally from s_rdata.
    always_comb begin
        mem.s_addr  = i;
        mem.s_wdata = 8'd0;
        mem.s_wren  = 1'b0;
        case (state)
            FILL: begin
                mem.s_wdata = i;
                mem.s_wren  = active;
            end
            KSA_RJ:         mem.s_addr = j + mem.s_rdata + key_byte;
            KSA_CJ, PR_CJ:  mem.s_addr = j;
            KSA_WI, PR_WI: begin
                mem.s_wdata = sj;
                mem.s_wren  = 1'b1;
            end
            KSA_WJ, PR_WJ: begin
                mem.s_addr  = j;
                mem.s_wdata = si;
                mem.s_wren  = 1'b1;
            end
            PR_RI:          mem.s_addr = i + 8'd1;
            PR_RJ:          mem.s_addr = j + mem.s_rdata;
            PR_RF:          mem.s_addr = si + sj;
            default:        mem.s_addr = i;
        endcase
    end

    assign mem.enc_addr  = k;
    assign mem.dec_addr  = k;
    assign mem.dec_wdata = f_q ^ e_q;
    assign mem.dec_wren  = (state == PR_WD);
    assign done          = (state == DONE);

endmodule

// File: tb/tb_rc4_decrypt.sv
// Bench for rc4_decrypt: known vector table plus randomized keys/ciphertext checked against a plain RC4 model.
`timescale 1ns/1ps
module tb_rc4_decrypt;

    localparam int MSG      = 32;
    localparam int FULL_RUN = 256 + 1280 + 8 * MSG;

    typedef struct {
        int         cyc;
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    typedef struct {
        logic [7:0] ct;
        logic [7:0] pt;
    } kv_t;

    logic        clk        = 1'b0;
    logic        reset      = 1'b1;
    logic        initialize = 1'b0;
    logic [23:0] key        = 24'd0;
    logic        done, invalid;

    rc4_decrypt_if #(.MSG_LEN(MSG)) bus ();

    rc4_decrypt #(.MSG_LEN(MSG)) dut (
        .clk        (clk),
        .reset      (reset),
        .key        (key),
        .initialize (initialize),
        .done       (done),
        .invalid    (invalid),
        .mem        (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] s_mem   [256];
    logic [7:0] enc_rom [MSG];

    // Synchronous memories with one cycle of read latency.
    always @(posedge clk) begin
        if (bus.s_wren === 1'b1) s_mem[bus.s_addr] <= bus.s_wdata;
        bus.s_rdata   <= s_mem[bus.s_addr];
        bus.enc_rdata <= enc_rom[bus.enc_addr];
    end

    int  cyc = 0;
    wr_t swr_log[$];
    wr_t dec_log[$];

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (bus.s_wren === 1'b1)   swr_log.push_back('{cyc, bus.s_addr, bus.s_wdata});
        if (bus.dec_wren === 1'b1) dec_log.push_back('{cyc, 8'(bus.dec_addr), bus.dec_wdata});
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    logic [7:0] exp_dec [MSG];
    logic [7:0] exp_s   [256];
    int         exp_nw;
    logic       exp_inv;

    // Textbook RC4 over the current ROM contents.
    task automatic model_run(input logic [23:0] k);
        int s [256];
        int kb [3];
        int mi, mj, t, f, d;
        kb = '{int'(k[23:16]), int'(k[15:8]), int'(k[7:0])};
        for (int n = 0; n < 256; n++) s[n] = n;
        mj = 0;
        for (int n = 0; n < 256; n++) begin
            mj = (mj + s[n] + kb[n % 3]) % 256;
            t = s[n]; s[n] = s[mj]; s[mj] = t;
        end
        mi = 0; mj = 0; exp_nw = 0; exp_inv = 1'b0;
        for (int n = 0; n < MSG; n++) begin
            mi = (mi + 1) % 256;
            mj = (mj + s[mi]) % 256;
            t = s[mi]; s[mi] = s[mj]; s[mj] = t;
            f = s[(s[mi] + s[mj]) % 256];
            d = f ^ int'(enc_rom[n]);
            exp_dec[n] = 8'(d);
            exp_nw = n + 1;
`ifdef RC4_EARLY_ABORT_EN
            if (!((d >= 97 && d <= 122) || d == 32)) begin
                exp_inv = 1'b1;
                break;
            end
`endif
        end
        for (int n = 0; n < 256; n++) exp_s[n] = 8'(s[n]);
    endtask

    task automatic fill_rom_random();
        for (int n = 0; n < MSG; n++) enc_rom[n] = 8'($urandom);
    endtask

    task automatic start_reset(input logic [23:0] k, output int sbase, output int dbase);
        @(negedge clk);
        #2;
        reset = 1'b1;
        key   = k;
        #1;
        check_output("reset_outputs",
                     {done, invalid, bus.s_wren, bus.dec_wren, bus.s_addr, bus.s_wdata, bus.enc_addr, bus.dec_addr},
                     64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        sbase = swr_log.size();
        dbase = dec_log.size();
    endtask

    task automatic apply_stimulus(input logic [23:0] k, input int hold,
                                  output int sbase, output int dbase, output int t0_req);
        int p;
        @(negedge clk);
        key        = k;
        initialize = 1'b1;
        p          = cyc;
        repeat (hold) @(posedge clk);
        #1;
        initialize = 1'b0;
        sbase      = swr_log.size();
        dbase      = dec_log.size();
        t0_req     = p + hold;
        @(negedge clk);
        check_output("init_done_low", done, 1'b0);
    endtask

    task automatic wait_done(input string name, input int limit, output int rise);
        rise = -1;
        while (cyc <= limit) begin
            @(negedge clk);
            if (done === 1'b1) begin
                rise = cyc;
                break;
            end
        end
        check_output({name, "_done_seen"}, done, 1'b1);
    endtask

    task automatic finish_run(input string name, input int sbase, input int dbase, input int t0_req);
        int t0, rise, good;
        wait_done(name, cyc + FULL_RUN + 40, rise);
        t0 = (swr_log.size() > sbase) ? swr_log[sbase].cyc : -1;
        if (t0_req >= 0) check_output({name, "_fill_start"}, t0, t0_req);
        good = 0;
        for (int n = 0; n < 256 && sbase + n < swr_log.size(); n++)
            if (swr_log[sbase + n].a == 8'(n) && swr_log[sbase + n].d == 8'(n) && swr_log[sbase + n].cyc == t0 + n)
                good++;
        check_output({name, "_fill_seq"}, good, 256);
        check_output({name, "_done_cycle"}, rise - t0, 256 + 1280 + 8 * exp_nw);
        good = 0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1) good++;
        end
        check_output({name, "_done_hold"}, good, 8);
        check_output({name, "_s_writes"}, swr_log.size() - sbase, 256 + 512 + 2 * exp_nw);
        check_output({name, "_dec_count"}, dec_log.size() - dbase, exp_nw);
        good = 0;
        for (int n = 0; n < exp_nw && dbase + n < dec_log.size(); n++)
            if (dec_log[dbase + n].a == 8'(n) && dec_log[dbase + n].d === exp_dec[n]) good++;
        check_output({name, "_dec_bytes"}, good, exp_nw);
        good = 0;
        for (int n = 0; n < 256; n++) if (s_mem[n] === exp_s[n]) good++;
        check_output({name, "_s_final"}, good, 256);
        check_output({name, "_invalid"}, invalid, exp_inv);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        kv_t         kv [9];
        int          sb, db, t0;
        logic [23:0] rk;
        logic [7:0]  got;

        kv = '{'{8'hBB, 8'h50}, '{8'hF3, 8'h6C}, '{8'h16, 8'h61}, '{8'hE8, 8'h69}, '{8'hD9, 8'h6E},
               '{8'h40, 8'h74}, '{8'hAF, 8'h65}, '{8'h0A, 8'h78}, '{8'hD3, 8'h74}};

        // Key 0 straight out of reset.
        fill_rom_random();
        model_run(24'd0);
        start_reset(24'd0, sb, db);
        finish_run("key0", sb, db, -1);

        // Known "Key"/"Plaintext" vector in the first nine ROM bytes.
        fill_rom_random();
        for (int n = 0; n < 9; n++) enc_rom[n] = kv[n].ct;
        model_run(24'h4B6579);
        apply_stimulus(24'h4B6579, 1, sb, db, t0);
        finish_run("known", sb, db, t0);
`ifndef RC4_EARLY_ABORT_EN
        for (int n = 0; n < 9; n++) begin
            got = (db + n < dec_log.size()) ? dec_log[db + n].d : 8'hxx;
            check_output($sformatf("known_pt%0d", n), got, kv[n].pt);
        end
`endif

        // Random keys and ciphertext.
        for (int r = 0; r < 3; r++) begin
            fill_rom_random();
            rk = 24'($urandom);
            model_run(rk);
            apply_stimulus(rk, 1, sb, db, t0);
            finish_run($sformatf("rand%0d", r), sb, db, t0);
        end

        // Restart mid key schedule with a new key.
        fill_rom_random();
        apply_stimulus(24'hA5A5A5, 1, sb, db, t0);
        while (cyc < t0 + 700) @(negedge clk);
        model_run(24'h000001);
        apply_stimulus(24'h000001, 1, sb, db, t0);
        finish_run("restart", sb, db, t0);

        // Initialize held high for several cycles.
        rk = 24'($urandom);
        model_run(rk);
        apply_stimulus(rk, 4, sb, db, t0);
        finish_run("held_init", sb, db, t0);

        // Asynchronous reset in the middle of the keystream phase.
        fill_rom_random();
        apply_stimulus(24'h13579B, 1, sb, db, t0);
        while (cyc < t0 + 1600) @(negedge clk);
        model_run(24'h2468AC);
        start_reset(24'h2468AC, sb, db);
        finish_run("after_reset", sb, db, -1);

        // First plaintext byte forced to 0x00.
        for (int n = 0; n < MSG; n++) enc_rom[n] = 8'h00;
        model_run(24'hC0FFEE);
        enc_rom[0] = exp_dec[0];
        for (int n = 1; n < MSG; n++) enc_rom[n] = 8'($urandom);
        model_run(24'hC0FFEE);
        apply_stimulus(24'hC0FFEE, 1, sb, db, t0);
        finish_run("zero_byte", sb, db, t0);
        got = (db < dec_log.size()) ? dec_log[db].d : 8'hxx;
        check_output("zero_byte_value", got, 8'h00);
`ifdef RC4_EARLY_ABORT_EN
        check_output("abort_invalid", invalid, 1'b1);
        check_output("abort_dec_pulses", dec_log.size() - db, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
